// File: rtl/jump_pkg.sv
// Shared definitions for the J-type jump encoder: opcodes, error bit indices
// and the buffered entry layout.
package jump_pkg;

  localparam logic [5:0] OP_J   = 6'h02;
  localparam logic [5:0] OP_JAL = 6'h03;

  localparam int ERR_ALIGN  = 0;
  localparam int ERR_REGION = 1;

  typedef struct packed {
    logic [31:0] inst;
    logic [1:0]  err;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

endpackage

// File: rtl/jump_inst_fifo.sv
// Two-entry in-order valid/ready buffer. push_ready depends only on the stored
// count, so there is no combinational path from pop_ready to push_ready.
module jump_inst_fifo #(
  parameter int W = 34
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_valid,
  output logic         push_ready,
  input  logic [W-1:0] push_data,
  output logic         pop_valid,
  input  logic         pop_ready,
  output logic [W-1:0] pop_data
);

  logic [W-1:0] mem [2];
  logic         rd_ptr;
  logic         wr_ptr;
  logic [1:0]   cnt;
  logic         push;
  logic         pop;

  assign push_ready = (cnt != 2'd2);
  assign pop_valid  = (cnt != 2'd0);
  assign pop_data   = mem[rd_ptr];
  assign push       = push_valid & push_ready;
  assign pop        = pop_valid & pop_ready;

  // Storage is cleared on reset so the head reads as all-zero afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/jump_inst_enc.sv
// J/JAL instruction encoder with region/alignment checking and a 2-entry output
// buffer. Optional saturating error counter enabled by JUMP_ERR_CNT_EN.
module jump_inst_enc
  import jump_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_target,
  input  logic        in_link,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [1:0]  out_err
`ifdef JUMP_ERR_CNT_EN
  ,output logic [15:0] err_cnt
`endif
);

  // Handshakes: a transfer happens on the rising edge where valid and ready are
  // both high; a producer holds its data stable until that edge, and ready
  // never depends combinationally on the opposite side's ready.

  logic [31:0] pc4;
  logic [1:0]  err;
  entry_t      entry;
  entry_t      head;
  logic        push;

  assign pc4 = in_pc + 32'd4;

  assign err[ERR_ALIGN]  = (in_target[1:0] != 2'b00);
  // Only the top nibble matters: the J field cannot change pc4[31:28].
  assign err[ERR_REGION] = (((in_target ^ pc4) >> 28) != 32'd0);

  always_comb begin
    entry.err  = err;
    entry.inst = 32'h0000_0000;
    if (err == 2'b00) begin
      entry.inst = {(in_link ? OP_JAL : OP_J), in_target[27:2]};
    end
  end

  assign push = in_valid & in_ready;

  jump_inst_fifo #(
    .W (ENTRY_W)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_valid (in_valid),
    .push_ready (in_ready),
    .push_data  (entry),
    .pop_valid  (out_valid),
    .pop_ready  (out_ready),
    .pop_data   (head)
  );

  assign out_inst = head.inst;
  assign out_err  = head.err;

`ifdef JUMP_ERR_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= 16'd0;
    end else if (push && (err != 2'b00) && (err_cnt != 16'hFFFF)) begin
      err_cnt <= err_cnt + 16'd1;
    end
  end
`else
  logic unused_push;
  assign unused_push = push;
`endif

endmodule

// File: tb/tb_jump_inst_enc.sv
// Self-checking bench for jump_inst_enc: directed vector table, backpressure and
// async-reset sequences, then randomized traffic against an arithmetic model.
module tb_jump_inst_enc;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_target;
  logic        in_link;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [1:0]  out_err;
`ifdef JUMP_ERR_CNT_EN
  logic [15:0] err_cnt;
`endif

  jump_inst_enc dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_target (in_target),
    .in_link   (in_link),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_inst  (out_inst),
    .out_err   (out_err)
`ifdef JUMP_ERR_CNT_EN
    ,.err_cnt  (err_cnt)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard state
  logic [33:0] exp_q[$];
  int          n_total = 0;
  int          n_pass  = 0;
  int          exp_errs = 0;

  task automatic check(input string name, input logic [33:0] act, input logic [33:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference: decode rules expressed as plain integer arithmetic.
  task automatic ref_enc(input logic [31:0] pc, input logic [31:0] tgt, input logic link,
                         output logic [31:0] inst, output logic [1:0] err);
    longint unsigned p4, t, op;
    p4 = (longint'(pc) + 4) % 64'h1_0000_0000;
    t  = longint'(tgt);
    err[0] = (t % 4) != 0;
    err[1] = (t / 64'h1000_0000) != (p4 / 64'h1000_0000);
    op = link ? 3 : 2;
    if (err != 2'b00) inst = 32'd0;
    else inst = 32'(op * 64'h400_0000 + (t % 64'h1000_0000) / 4);
  endtask

  // One clock: check status against the model, score any pop, record any push.
  task automatic step();
    logic [31:0] ei;
    logic [1:0]  ee;
    logic [33:0] head;
    check("in_ready", {33'd0, in_ready}, {33'd0, exp_q.size() != 2});
    check("out_valid", {33'd0, out_valid}, {33'd0, exp_q.size() != 0});
    if (out_valid && out_ready && exp_q.size() > 0) begin
      head = exp_q.pop_front();
      check("out_word", {out_inst, out_err}, head);
    end
    if (in_valid && in_ready) begin
      ref_enc(in_pc, in_target, in_link, ei, ee);
      exp_q.push_back({ei, ee});
      if (ee != 2'b00 && exp_errs != 65535) exp_errs++;
    end
    @(posedge clk);
    @(negedge clk);
`ifdef JUMP_ERR_CNT_EN
    check("err_cnt", {18'd0, err_cnt}, 34'(exp_errs));
`endif
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] tgt, input logic link);
    in_valid  = 1'b1;
    in_pc     = pc;
    in_target = tgt;
    in_link   = link;
  endtask

  typedef struct {
    logic [31:0] pc;
    logic [31:0] tgt;
    logic        link;
    logic [31:0] inst;
    logic [1:0]  err;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [31:0] held;
    logic        accepted;
    logic [31:0] rpc, rtgt, rp4;

    vecs[0] = '{32'h0040_0000, 32'h0040_0100, 1'b0, 32'h0810_0040, 2'b00};
    vecs[1] = '{32'h0040_0000, 32'h0040_0100, 1'b1, 32'h0C10_0040, 2'b00};
    vecs[2] = '{32'h0040_0000, 32'h1000_0000, 1'b0, 32'h0000_0000, 2'b10};
    vecs[3] = '{32'h0FFF_FFFC, 32'h1000_0008, 1'b0, 32'h0800_0002, 2'b00};
    vecs[4] = '{32'hFFFF_FFFC, 32'h0000_0010, 1'b0, 32'h0800_0004, 2'b00};
    vecs[5] = '{32'h0040_0000, 32'h0040_0102, 1'b1, 32'h0000_0000, 2'b01};
    vecs[6] = '{32'h0000_0000, 32'h2000_0001, 1'b1, 32'h0000_0000, 2'b11};

    rst_n = 1'b0; in_valid = 1'b0; in_pc = '0; in_target = '0; in_link = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    check("rst_in_ready", {33'd0, in_ready}, 34'd1);
    check("rst_out_valid", {33'd0, out_valid}, 34'd0);
    check("rst_out_word", {out_inst, out_err}, 34'd0);
`ifdef JUMP_ERR_CNT_EN
    check("rst_err_cnt", {18'd0, err_cnt}, 34'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // Directed table: accept, then the word must be at the head one edge later.
    out_ready = 1'b1;
    foreach (vecs[i]) begin
      drive(vecs[i].pc, vecs[i].tgt, vecs[i].link);
      step();
      in_valid = 1'b0;
      check($sformatf("vec%0d_valid", i), {33'd0, out_valid}, 34'd1);
      check($sformatf("vec%0d_word", i), {out_inst, out_err}, {vecs[i].inst, vecs[i].err});
      step();
    end

    // Backpressure: two accepted, third blocked, head stays stable.
    out_ready = 1'b0;
    drive(vecs[0].pc, vecs[0].tgt, vecs[0].link);
    step();
    held = out_inst;
    check("bp_head", {held, out_err}, {vecs[0].inst, vecs[0].err});
    drive(vecs[1].pc, vecs[1].tgt, vecs[1].link);
    step();
    drive(vecs[3].pc, vecs[3].tgt, vecs[3].link);
    for (int k = 0; k < 3; k++) begin
      check("bp_full_ready", {33'd0, in_ready}, 34'd0);
      step();
      check("bp_stable", {2'd0, out_inst}, {2'd0, vecs[0].inst});
    end
    out_ready = 1'b1;
    step();
    check("bp_ready_rise", {33'd0, in_ready}, 34'd1);
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) step();

    // Misaligned entry at head, then async reset between edges.
    out_ready = 1'b0;
    drive(vecs[0].pc, vecs[0].tgt, 1'b0);
    step();
    drive(32'h0040_0000, 32'h0040_0102, 1'b0);
    step();
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("misalign_err", {out_inst, out_err}, {32'd0, 2'b01});
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", {33'd0, out_valid}, 34'd0);
    check("arst_in_ready", {33'd0, in_ready}, 34'd1);
    check("arst_out_word", {out_inst, out_err}, 34'd0);
`ifdef JUMP_ERR_CNT_EN
    check("arst_err_cnt", {18'd0, err_cnt}, 34'd0);
`endif
    exp_q.delete();
    exp_errs = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Randomized traffic; a pending request is held until accepted.
    in_valid = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!in_valid && $urandom_range(0, 3) != 0) begin
        rpc = $urandom;
        if ($urandom_range(0, 4) == 0) rpc = {rpc[31:28], 28'hFFF_FFFC};
        rp4 = rpc + 32'd4;
        rtgt = $urandom;
        if ($urandom_range(0, 9) < 7) rtgt[31:28] = rp4[31:28];
        if ($urandom_range(0, 4) != 0) rtgt[1:0] = 2'b00;
        drive(rpc, rtgt, 1'($urandom_range(0, 1)));
      end
      out_ready = ($urandom_range(0, 3) != 0);
      accepted = in_valid && in_ready;
      step();
      if (accepted) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) step();
    check("drain_empty", {33'd0, out_valid}, 34'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
